// File: rtl/fourth_task_arbiter.sv
// Round-robin arbiter that shares one external combinational 8->16 datapath
// between two valid/ready requesters and returns tagged results.
module fourth_task_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [7:0]  dp_in,
  input  logic [15:0] dp_out,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  input  logic        rsp_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic       ptr;
  logic [3:0] cnt;
  logic       accept;

  // Grants are only offered in IDLE; ptr names the requester that wins a tie.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_nxt  = state;
    unique case (state)
      IDLE: begin
        req0_ready = req0_valid & (~ptr | ~req1_valid);
        req1_ready = req1_valid & (ptr | ~req0_valid);
        if (req0_ready | req1_ready) state_nxt = SETTLE;
      end
      SETTLE: if (cnt == 4'd0) state_nxt = RESP;
      RESP:   if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = req0_ready | req1_ready;
  assign busy   = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= 1'b0;
      cnt       <= 4'd0;
      dp_in     <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            dp_in  <= req1_ready ? req1_data : req0_data;
            rsp_id <= req1_ready;
            cnt    <= CNT_INIT;
          end
        end
        SETTLE: begin
          // dp_in has been stable for SETTLE_CYCLES edges once cnt reaches 0.
          if (cnt == 4'd0) begin
            rsp_data  <= dp_out;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= ~rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fourth_task_arbiter.sv
// Scoreboard bench for fourth_task_arbiter: a SETTLE_CYCLES=1 instance for the
// arbitration scenarios and a SETTLE_CYCLES=4 instance for settle timing.
module tb_fourth_task_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_data, req1_data, dp_in;
  logic [15:0] dp_out, rsp_data;
  logic        rsp_valid, rsp_id, rsp_ready, busy;

  logic        s4_req0_valid, s4_req0_ready, s4_req1_valid, s4_req1_ready;
  logic [7:0]  s4_req0_data, s4_req1_data, s4_dp_in;
  logic [15:0] s4_dp_out, s4_rsp_data;
  logic        s4_rsp_valid, s4_rsp_id, s4_rsp_ready, s4_busy;

  function automatic logic [15:0] dp_model(input logic [7:0] d);
    return {d, d ^ 8'hFF};
  endfunction

  assign dp_out    = dp_model(dp_in);
  assign s4_dp_out = dp_model(s4_dp_in);

  fourth_task_arbiter #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .dp_in(dp_in), .dp_out(dp_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  fourth_task_arbiter #(.SETTLE_CYCLES(4)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s4_req0_valid), .req0_data(s4_req0_data), .req0_ready(s4_req0_ready),
    .req1_valid(s4_req1_valid), .req1_data(s4_req1_data), .req1_ready(s4_req1_ready),
    .dp_in(s4_dp_in), .dp_out(s4_dp_out),
    .rsp_valid(s4_rsp_valid), .rsp_id(s4_rsp_id), .rsp_data(s4_rsp_data), .rsp_ready(s4_rsp_ready),
    .busy(s4_busy)
  );

  typedef struct packed {
    logic        id;
    logic [15:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  // Inputs only change just after posedge, so the negedge view is exactly what
  // the next posedge will see.
  task automatic sample();
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (req0_valid && req0_ready) sb_q.push_back('{1'b0, dp_model(req0_data)});
      if (req1_valid && req1_ready) sb_q.push_back('{1'b1, dp_model(req1_data)});
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_unexpected: got id %0d data %h, want no response", rsp_id, rsp_data);
        end else begin
          e = sb_q.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data)
            $display("FAIL sb_response: got id %0d data %h, want id %0d data %h",
                     rsp_id, rsp_data, e.id, e.data);
          else passes++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    s4_req0_valid = 1'b0; s4_req1_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_rsp(input int max_cycles, input string tag);
    int n = 0;
    while (!rsp_valid && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (!rsp_valid) $display("FAIL %s_rsp_timeout: got no rsp_valid in %0d cycles, want rsp_valid=1", tag, max_cycles);
    else passes++;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rsp_ready = 1'b1;
    while ((busy || rsp_valid || sb_q.size() != 0) && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (busy || sb_q.size() != 0)
      $display("FAIL %s_drain: got busy=%b pending=%0d, want busy=0 pending=0", tag, busy, sb_q.size());
    else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00; rsp_ready = 1'b0;
    s4_req0_valid = 1'b0; s4_req1_valid = 1'b0; s4_req0_data = 8'h00; s4_req1_data = 8'h00;
    s4_rsp_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_id !== 1'b0)
      $display("FAIL reset_ctrl: got busy=%b rsp_valid=%b rsp_id=%b, want 0 0 0", busy, rsp_valid, rsp_id);
    else passes++;
    checks++;
    if (dp_in !== 8'h00 || rsp_data !== 16'h0000)
      $display("FAIL reset_data: got dp_in=%h rsp_data=%h, want 00 0000", dp_in, rsp_data);
    else passes++;
    checks++;
    if (s4_busy !== 1'b0 || s4_rsp_valid !== 1'b0 || s4_dp_in !== 8'h00)
      $display("FAIL reset_s4: got busy=%b rsp_valid=%b dp_in=%h, want 0 0 00", s4_busy, s4_rsp_valid, s4_dp_in);
    else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req0_data = 8'h03; req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL single_grant: got req0_ready=%b busy=%b, want 1 0", req0_ready, busy);
    else passes++;
    tick();
    checks++;
    if (req0_ready !== 1'b0 || busy !== 1'b1 || dp_in !== 8'h03 || rsp_valid !== 1'b0)
      $display("FAIL single_settle: got ready=%b busy=%b dp_in=%h rsp_valid=%b, want 0 1 03 0",
               req0_ready, busy, dp_in, rsp_valid);
    else passes++;
    req0_valid = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'h03FC || busy !== 1'b1)
      $display("FAIL single_rsp: got valid=%b id=%b data=%h busy=%b, want 1 0 03fc 1",
               rsp_valid, rsp_id, rsp_data, busy);
    else passes++;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || dp_in !== 8'h03)
      $display("FAIL single_done: got valid=%b busy=%b dp_in=%h, want 0 0 03", rsp_valid, busy, dp_in);
    else passes++;
  endtask

  task automatic test_tie();
    do_reset();
    rsp_ready = 1'b1;
    req0_data = 8'h02; req1_data = 8'h05;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      logic want;
      want = logic'(k % 2);
      while (!(req0_ready || req1_ready) && n < 10) begin
        tick();
        n++;
      end
      checks++;
      if (!(req0_ready ^ req1_ready) || req1_ready !== want)
        $display("FAIL tie_grant%0d: got r0=%b r1=%b, want grant to %0d", k, req0_ready, req1_ready, want);
      else passes++;
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("tie");
  endtask

  task automatic test_backpressure();
    logic [15:0] want_data;
    want_data = dp_model(8'h11);
    rsp_ready = 1'b0;
    req0_data = 8'h11; req1_data = 8'h22;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL bp_grant: got r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
    else passes++;
    tick();
    req0_valid = 1'b0;
    wait_rsp(10, "bp");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== want_data || req1_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got valid=%b id=%b data=%h r1=%b, want 1 0 %h 0",
                 i, rsp_valid, rsp_id, rsp_data, req1_ready, want_data);
      else passes++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    tick();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req1_ready !== 1'b1)
      $display("FAIL bp_release: got busy=%b valid=%b r1=%b, want 0 0 1", busy, rsp_valid, req1_ready);
    else passes++;
    tick();
    checks++;
    if (busy !== 1'b1 || dp_in !== 8'h22)
      $display("FAIL bp_next: got busy=%b dp_in=%h, want 1 22", busy, dp_in);
    else passes++;
    req1_valid = 1'b0;
    drain("bp");
  endtask

  task automatic test_settle();
    s4_rsp_ready = 1'b1;
    s4_req1_data = 8'h04; s4_req1_valid = 1'b1;
    #1;
    checks++;
    if (s4_req1_ready !== 1'b1)
      $display("FAIL settle_grant: got r1=%b, want 1", s4_req1_ready);
    else passes++;
    tick();
    s4_req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s4_rsp_valid !== 1'b0 || s4_dp_in !== 8'h04 || s4_busy !== 1'b1)
        $display("FAIL settle_wait%0d: got valid=%b dp_in=%h busy=%b, want 0 04 1",
                 i, s4_rsp_valid, s4_dp_in, s4_busy);
      else passes++;
      tick();
    end
    checks++;
    if (s4_rsp_valid !== 1'b1 || s4_rsp_id !== 1'b1 || s4_rsp_data !== 16'h04FB)
      $display("FAIL settle_rsp: got valid=%b id=%b data=%h, want 1 1 04fb", s4_rsp_valid, s4_rsp_id, s4_rsp_data);
    else passes++;
    tick();
    checks++;
    if (s4_rsp_valid !== 1'b0 || s4_busy !== 1'b0 || s4_dp_in !== 8'h04)
      $display("FAIL settle_done: got valid=%b busy=%b dp_in=%h, want 0 0 04", s4_rsp_valid, s4_busy, s4_dp_in);
    else passes++;
    // After serving requester 1, requester 0 wins the tie; then both withdraw.
    s4_req0_data = 8'h77; s4_req0_valid = 1'b1; s4_req1_valid = 1'b1;
    #1;
    checks++;
    if (s4_req0_ready !== 1'b1 || s4_req1_ready !== 1'b0)
      $display("FAIL settle_rr: got r0=%b r1=%b, want 1 0", s4_req0_ready, s4_req1_ready);
    else passes++;
    s4_req0_valid = 1'b0; s4_req1_valid = 1'b0;
    tick();
    checks++;
    if (s4_busy !== 1'b0 || s4_dp_in !== 8'h04)
      $display("FAIL withdraw: got busy=%b dp_in=%h, want 0 04", s4_busy, s4_dp_in);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    rsp_ready = 1'b1;
    req0_data = 8'h33; req0_valid = 1'b1;
    #1;
    tick();
    req0_valid = 1'b0;
    checks++;
    if (busy !== 1'b1)
      $display("FAIL rmid_busy: got busy=%b, want 1", busy);
    else passes++;
    rst_n = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || dp_in !== 8'h00 || busy !== 1'b0)
      $display("FAIL rmid_clear: got valid=%b dp_in=%h busy=%b, want 0 00 0", rsp_valid, dp_in, busy);
    else passes++;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0)
      $display("FAIL rmid_ghost: got rsp_valid=1 for dropped request, want none");
    else passes++;
    req0_data = 8'h44; req1_data = 8'h55;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL rmid_tie: got r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
    else passes++;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("rmid");
  endtask

  task automatic test_lone();
    localparam int SPACING = 1 + 2;
    int last = -1;
    int n_acc = 0;
    logic acc;
    rsp_ready = 1'b1;
    req1_data = 8'h60; req1_valid = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      acc = req1_ready;
      if (acc) begin
        if (last >= 0) begin
          checks++;
          if (c - last != SPACING)
            $display("FAIL lone_gap: got %0d cycles, want %0d", c - last, SPACING);
          else passes++;
        end
        last = c;
        n_acc++;
      end
      tick();
      if (acc) req1_data = req1_data + 8'h01;
    end
    checks++;
    if (n_acc != 4)
      $display("FAIL lone_count: got %0d acceptances, want 4", n_acc);
    else passes++;
    req1_valid = 1'b0;
    drain("lone");
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_settle();
    test_reset_mid();
    test_lone();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
